// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus controller slice.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam int unsigned DEV_IDX_W = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;

    // Width of the page index left after stripping the in-page offset.
    function automatic int unsigned page_idx_w(input int unsigned page_bits);
        return ADDR_W - page_bits;
    endfunction

endpackage

// File: rtl/periph_addr_decoder.sv
// Combinational page decoder: maps a core byte address onto a device slot index.
module periph_addr_decoder
    import periph_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000,
    parameter int unsigned PAGE_BITS    = 12,
    parameter int unsigned NUM_DEVICES  = 4
) (
    input  logic [31:0]          core_address,
    output logic                 mapped,
    output logic [DEV_IDX_W-1:0] dev_idx
);

    localparam int unsigned PIW = page_idx_w(PAGE_BITS);

    logic [31:0]    offset;
    logic [PIW-1:0] page;
    logic           above_base;

    always_comb begin
        offset     = core_address - BASE_ADDRESS;
        page       = PIW'(offset >> PAGE_BITS);
        // A wrapped subtraction would alias into low pages, so gate it explicitly.
        above_base = (core_address >= BASE_ADDRESS);
        mapped     = above_base && (32'(page) < NUM_DEVICES);
        dev_idx    = mapped ? page[DEV_IDX_W-1:0] : '0;
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: decodes core accesses into held one-hot device strobes.
// Optional BUS_TIMEOUT_EN bounds each device access to TIMEOUT_CYCLES cycles.
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_1000,
    parameter int unsigned PAGE_BITS      = 12,
    parameter int unsigned NUM_DEVICES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      core_read,
    input  logic                      core_write,
    input  logic [31:0]               core_address,
    input  logic [31:0]               core_write_data,
    output logic [31:0]               core_read_data,
    output logic                      core_ack,
    output logic                      core_err,
    output logic [NUM_DEVICES-1:0]    dev_read,
    output logic [NUM_DEVICES-1:0]    dev_write,
    output logic [31:0]               dev_address,
    output logic [31:0]               dev_write_data,
    input  logic [32*NUM_DEVICES-1:0] dev_read_data,
    input  logic [NUM_DEVICES-1:0]    dev_response
);

    if (NUM_DEVICES < 1 || NUM_DEVICES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("periph_bus_ctrl: unsupported NUM_DEVICES or TIMEOUT_CYCLES");
    end

    bus_state_t             state_q;
    logic [NUM_DEVICES-1:0] dev_read_q;
    logic [NUM_DEVICES-1:0] dev_write_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic [DEV_IDX_W-1:0]   idx_q;
    logic                   write_q;
    logic                   ack_q;
    logic                   err_q;

    logic                   dec_mapped;
    logic [DEV_IDX_W-1:0]   dec_idx;
    logic [NUM_DEVICES-1:0] dec_oh;
    logic                   sel_resp;
    logic [31:0]            sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    periph_addr_decoder #(
        .BASE_ADDRESS (BASE_ADDRESS),
        .PAGE_BITS    (PAGE_BITS),
        .NUM_DEVICES  (NUM_DEVICES)
    ) u_decoder (
        .core_address (core_address),
        .mapped       (dec_mapped),
        .dev_idx      (dec_idx)
    );

    // Only the latched slot's response and data are observed.
    always_comb begin
        dec_oh    = '0;
        sel_resp  = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
            dec_oh[i] = (dec_idx == DEV_IDX_W'(i));
            if (idx_q == DEV_IDX_W'(i)) begin
                sel_resp  = dev_response[i];
                sel_rdata = dev_read_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dev_read_q  <= '0;
            dev_write_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (core_read && core_write) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (core_read || core_write) begin
                        addr_q  <= core_address;
                        wdata_q <= core_write_data;
                        write_q <= core_write;
                        idx_q   <= dec_idx;
                        if (dec_mapped) begin
                            state_q     <= ACCESS;
                            dev_read_q  <= core_read  ? dec_oh : '0;
                            dev_write_q <= core_write ? dec_oh : '0;
`ifdef BUS_TIMEOUT_EN
                            to_cnt_q    <= '0;
`endif
                        end else begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_resp) begin
                        state_q     <= RESP;
                        ack_q       <= 1'b1;
                        rdata_q     <= write_q ? '0 : sel_rdata;
                        dev_read_q  <= '0;
                        dev_write_q <= '0;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Response is checked first so a reply on the final cycle still succeeds.
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= RESP;
                        ack_q       <= 1'b1;
                        err_q       <= 1'b1;
                        dev_read_q  <= '0;
                        dev_write_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_read_data = rdata_q;
    assign core_ack       = ack_q;
    assign core_err       = err_q;
    assign dev_read       = dev_read_q;
    assign dev_write      = dev_write_q;
    assign dev_address    = addr_q;
    assign dev_write_data = wdata_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Randomized bench for periph_bus_ctrl and its address decoder against a transaction-level model.
`timescale 1ns/1ps
module tb_periph_bus_ctrl;

    localparam int unsigned NDEV = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned PB   = 12;
    localparam int unsigned TO   = 16;
    localparam int unsigned PAGE = 1 << PB;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                core_read = 1'b0;
    logic                core_write = 1'b0;
    logic [31:0]         core_address = '0;
    logic [31:0]         core_write_data = '0;
    logic [31:0]         core_read_data;
    logic                core_ack;
    logic                core_err;
    logic [NDEV-1:0]     dev_read;
    logic [NDEV-1:0]     dev_write;
    logic [31:0]         dev_address;
    logic [31:0]         dev_write_data;
    logic [32*NDEV-1:0]  dev_read_data = '0;
    logic [NDEV-1:0]     dev_response;

    logic [31:0]         ut_addr = '0;
    logic                ut_mapped;
    logic [3:0]          ut_idx;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Device model: each device replies after wait_w strobe cycles; others emit noise.
    int unsigned         wait_w = 0;
    int unsigned         strobe_cycles = 0;
    logic [NDEV-1:0]     noise = '0;
    logic [NDEV-1:0]     strobes;

    always #5 clk = ~clk;

    periph_bus_ctrl #(
        .BASE_ADDRESS   (BASE),
        .PAGE_BITS      (PB),
        .NUM_DEVICES    (NDEV),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_read       (core_read),
        .core_write      (core_write),
        .core_address    (core_address),
        .core_write_data (core_write_data),
        .core_read_data  (core_read_data),
        .core_ack        (core_ack),
        .core_err        (core_err),
        .dev_read        (dev_read),
        .dev_write       (dev_write),
        .dev_address     (dev_address),
        .dev_write_data  (dev_write_data),
        .dev_read_data   (dev_read_data),
        .dev_response    (dev_response)
    );

    periph_addr_decoder #(
        .BASE_ADDRESS (BASE),
        .PAGE_BITS    (PB),
        .NUM_DEVICES  (NDEV)
    ) u_dec_ut (
        .core_address (ut_addr),
        .mapped       (ut_mapped),
        .dev_idx      (ut_idx)
    );

    always @(posedge clk) strobe_cycles <= (|strobes) ? strobe_cycles + 1 : 0;

    always_comb begin
        strobes      = dev_read | dev_write;
        dev_response = (noise & ~strobes) | ((strobe_cycles >= wait_w) ? strobes : '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_mapped(input logic [31:0] addr);
        if (addr < BASE) return 1'b0;
        return ((addr - BASE) / PAGE) < NDEV;
    endfunction

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned w,
                           input logic [31:0] slot_val);
        logic            mapped;
        int unsigned     page;
        logic [NDEV-1:0] oh;
        logic [31:0]     exp_data;
        logic            exp_err;
        int unsigned     exp_lat;
        int unsigned     exp_strobe_n;
        int unsigned     lat;
        logic [NDEV-1:0] exp_rd;
        logic [NDEV-1:0] exp_wr;

        mapped = ref_mapped(addr);
        page   = mapped ? (addr - BASE) / PAGE : 0;
        oh     = '0;
        wait_w = w;
        noise  = NDEV'($urandom);
        for (int i = 0; i < NDEV; i++) dev_read_data[32*i +: 32] = $urandom;
        if (mapped) dev_read_data[32*page +: 32] = slot_val;

        exp_data = '0;
        if ((rd && wr) || !mapped) begin
            exp_err      = 1'b1;
            exp_strobe_n = 0;
            exp_lat      = 1;
        end else begin
            oh[page]     = 1'b1;
            exp_err      = 1'b0;
            exp_strobe_n = w + 1;
            exp_data     = rd ? slot_val : 32'h0;
`ifdef BUS_TIMEOUT_EN
            if (w + 1 > TO) begin
                exp_strobe_n = TO;
                exp_err      = 1'b1;
                exp_data     = '0;
            end
`endif
            exp_lat = exp_strobe_n + 1;
        end

        core_read       = rd;
        core_write      = wr;
        core_address    = addr;
        core_write_data = wdata;
        @(posedge clk); #1;
        core_read  = 1'b0;
        core_write = 1'b0;

        lat = 0;
        for (int unsigned k = 1; k <= exp_lat + 8 && lat == 0; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            exp_rd = (k <= exp_strobe_n && !wr) ? oh : '0;
            exp_wr = (k <= exp_strobe_n &&  wr) ? oh : '0;
            check("dev_read", 32'(dev_read), 32'(exp_rd));
            check("dev_write", 32'(dev_write), 32'(exp_wr));
            if (k == 1 && exp_strobe_n > 0) begin
                check("dev_address", dev_address, addr);
                check("dev_write_data", dev_write_data, wdata);
            end
            if (core_ack) begin
                lat = k;
                check("ack_err", 32'(core_err), 32'(exp_err));
                check("ack_rdata", core_read_data, exp_data);
            end else begin
                check("rdata_no_ack", core_read_data, 32'h0);
            end
        end
        check("latency", lat, exp_lat);
        @(posedge clk); #1;
        check("ack_single_pulse", 32'(core_ack), 32'h0);
    endtask

    initial begin
        int unsigned acks;
        int unsigned bad;
        int unsigned sel;
        logic [31:0] addr;
        logic [31:0] bnd [8];
        logic        rd;
        logic        wr;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(core_ack), 32'h0);
        check("rst_err", 32'(core_err), 32'h0);
        check("rst_rdata", core_read_data, 32'h0);
        check("rst_strobes", 32'({dev_write, dev_read}), 32'h0);
        check("rst_addr", dev_address, 32'h0);
        check("rst_wdata", dev_write_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(1'b0, 1'b1, 32'h0000_1000, 32'h0000_00A5, 0, 32'h1234_5678);
        run_txn(1'b1, 1'b0, 32'h0000_2004, 32'h0, 0, 32'hDEAD_BEEF);
        run_txn(1'b1, 1'b0, 32'h0000_8000, 32'h0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_4FFF, 32'h0, 2, 32'h0BAD_CAFE);
        run_txn(1'b1, 1'b0, 32'h0000_5000, 32'h0, 0, 32'h0);
        run_txn(1'b1, 1'b1, 32'h0000_1000, 32'h55, 0, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_3010, 32'h0, 15, 32'h0F0F_0F0F);
        run_txn(1'b1, 1'b0, 32'h0000_3010, 32'h0, 16, 32'hF0F0_F0F0);
        run_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 39, 32'h4040_4040);

`ifdef BUS_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 2000, 32'h0);
`else
        wait_w       = 2000;
        noise        = '0;
        core_read    = 1'b1;
        core_address = 32'h0000_3000;
        @(posedge clk); #1;
        core_read = 1'b0;
        acks = 0;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            if (core_ack) acks++;
            if (dev_read !== 4'b0100) bad++;
            @(posedge clk); #1;
        end
        check("no_ack_hung", acks, 0);
        check("strobe_held_hung", bad, 0);
        dev_read_data[32*2 +: 32] = 32'hCAFE_F00D;
        wait_w = 0;
        @(posedge clk); #1;
        check("late_ack", 32'(core_ack), 32'h1);
        check("late_err", 32'(core_err), 32'h0);
        check("late_rdata", core_read_data, 32'hCAFE_F00D);
        @(posedge clk); #1;
        check("late_ack_pulse", 32'(core_ack), 32'h0);
`endif

        wait_w       = 3;
        core_read    = 1'b1;
        core_address = 32'h0000_3008;
        @(posedge clk); #1;
        core_read = 1'b0;
        check("pre_rst_strobe", 32'(dev_read), 32'h4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_strobes", 32'({dev_write, dev_read}), 32'h0);
        check("midrst_ack", 32'(core_ack), 32'h0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (core_ack || (|strobes)) acks++;
        end
        check("midrst_abandoned", acks, 0);
        run_txn(1'b0, 1'b1, 32'h0000_3008, 32'h0000_7777, 3, 32'h0);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            rd  = 1'b0;
            wr  = 1'b0;
            if ($urandom_range(0, 1) == 1) rd = 1'b1;
            else wr = 1'b1;
            if (sel <= 5)      addr = BASE + $urandom_range(0, NDEV - 1) * PAGE + $urandom_range(0, PAGE - 1);
            else if (sel == 6) addr = $urandom_range(0, BASE - 1);
            else if (sel == 7) addr = BASE + NDEV * PAGE + $urandom_range(0, 32'h0FFF_FFFF);
            else if (sel == 8) addr = $urandom;
            else begin
                addr = BASE + $urandom_range(0, NDEV * PAGE - 1);
                rd   = 1'b1;
                wr   = 1'b1;
            end
            run_txn(rd, wr, addr, $urandom,
                    ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
                    $urandom);
        end

        bnd[0] = 32'h0000_0000;
        bnd[1] = 32'h0000_0FFF;
        bnd[2] = 32'h0000_1000;
        bnd[3] = 32'h0000_1FFF;
        bnd[4] = 32'h0000_4FFF;
        bnd[5] = 32'h0000_5000;
        bnd[6] = 32'hFFFF_FFFF;
        bnd[7] = 32'h8000_1000;
        for (int n = 0; n < 48; n++) begin
            ut_addr = (n < 8) ? bnd[n] : ((n % 2 == 0) ? $urandom : BASE + $urandom_range(0, 6 * PAGE));
            #1;
            check("dec_mapped", 32'(ut_mapped), 32'(ref_mapped(ut_addr)));
            if (ref_mapped(ut_addr)) check("dec_idx", 32'(ut_idx), (ut_addr - BASE) / PAGE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
